// File: rtl/mmio_tty_fifo.sv
// mmio_tty_fifo: memory-mapped TTY with TX/RX byte FIFOs, sticky overflow flags and a paced TX drain FSM
module mmio_tty_fifo #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'h4000,
  parameter int DEPTH = 8,
  parameter int TX_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data,
  output logic [31:0]           out,
  input  logic                  rd,
  input  logic                  wr,
  output logic [7:0]            tx_char,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_char,
  input  logic                  rx_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = TX_GAP > 1 ? $clog2(TX_GAP) : 1;
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = BASE_ADDR + 1'b1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_char_q, tx_char_d;
  logic          sel_data, sel_stat, tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, stat_rd;
  logic [31:0]   status, rdata;

  function automatic logic [7:0] sat8(input int c);
    return c > 255 ? 8'hFF : 8'(c);
  endfunction

  // Case equality keeps X/Z address bits from ever selecting a register.
  assign sel_data = addr === BASE_ADDR;
  assign sel_stat = addr === STAT_ADDR;
  assign out      = (rst && rd && (sel_data || sel_stat)) ? rdata : 'z;
  assign tx_valid = tx_valid_q;
  assign tx_char  = tx_char_q;

  // FIFO bookkeeping, overflow flags and read mux; full/empty are sampled at cycle start so a pop never frees room for a same-cycle push.
  always_comb begin
    tx_full  = tx_cnt_q == CW'(DEPTH);
    tx_empty = tx_cnt_q == '0;
    rx_full  = rx_cnt_q == CW'(DEPTH);
    rx_empty = rx_cnt_q == '0;
    tx_push  = wr && sel_data && !tx_full;
    tx_pop   = state_q == SEND && tx_ready;
    rx_push  = rx_valid && !rx_full;
    rx_pop   = rd && sel_data && !rx_empty;
    stat_rd  = rd && sel_stat;
    tx_wp_d  = tx_wp_q + PW'(tx_push);
    tx_rp_d  = tx_rp_q + PW'(tx_pop);
    rx_wp_d  = rx_wp_q + PW'(rx_push);
    rx_rp_d  = rx_rp_q + PW'(rx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_ovf_d = (wr && sel_data && tx_full) || (tx_ovf_q && !stat_rd);
    rx_ovf_d = (rx_valid && rx_full) || (rx_ovf_q && !stat_rd);
    status   = {8'h00, sat8(int'(rx_cnt_q)), sat8(int'(tx_cnt_q)), 2'b00,
                tx_ovf_q, rx_ovf_q, rx_full, rx_empty, tx_empty, tx_full};
    rdata    = sel_data ? {24'h0, rx_empty ? 8'h00 : rx_mem_q[rx_rp_q]} : status;
  end

  // TX drain: load the head on entering SEND, pop on handshake, then hold off for TX_GAP cycles.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    tx_valid_d = tx_valid_q;
    tx_char_d  = tx_char_q;
    case (state_q)
      IDLE: if (!tx_empty) begin
        state_d    = SEND;
        tx_valid_d = 1'b1;
        tx_char_d  = tx_mem_q[tx_rp_q];
      end
      SEND: if (tx_ready) begin
        state_d    = TX_GAP > 0 ? GAP : IDLE;
        tx_valid_d = 1'b0;
        gap_d      = GW'(TX_GAP > 0 ? TX_GAP - 1 : 0);
      end
      GAP: begin
        state_d = gap_q == '0 ? IDLE : GAP;
        gap_d   = gap_q == '0 ? gap_q : gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage needs no reset; the pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= data[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_char;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      state_q    <= IDLE;
      gap_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_char_q  <= 8'h00;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      tx_valid_q <= tx_valid_d;
      tx_char_q  <= tx_char_d;
    end
  end
endmodule

// File: tb/tb_mmio_tty_fifo.sv
// tb_mmio_tty_fifo: directed scenario bench for mmio_tty_fifo
module tb_mmio_tty_fifo;
  localparam logic [15:0] BASE = 16'h4000;
  localparam logic [15:0] STAT = 16'h4001;
  localparam logic [31:0] HIZ  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic [31:0] data = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [7:0]  tx_char;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_char = '0;
  logic        rx_valid = 1'b0;
  wire  [31:0] out_w;
  int          n_cmp = 0;
  int          n_err = 0;

  // An undriven bus floats up, so high-Z reads back as all ones.
  pullup (out_w);

  mmio_tty_fifo #(.ADDR_WIDTH(16), .BASE_ADDR(16'h4000), .DEPTH(8), .TX_GAP(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .out(out_w), .rd(rd), .wr(wr),
    .tx_char(tx_char), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_char(rx_char), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  task automatic bus_read(input logic [15:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a;
    rd = 1'b1;
    #1 v = out_w;
    @(posedge clk);
    #1 rd = 1'b0;
    addr = '0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    data = {24'h0, d};
    wr = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    addr = '0;
  endtask

  task automatic rx_pulse(input logic [7:0] c);
    @(negedge clk);
    rx_char = c;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    #1 rst = 1'b0;
    addr = STAT;
    rd = 1'b1;
    #3;
    n_cmp++; if (out_w !== HIZ) begin n_err++; $display("FAIL reset_out_hiz: got %h want %h", out_w, HIZ); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0000_0006) begin n_err++; $display("FAIL reset_status: got %h want %h", v, 32'h6); end
    @(negedge clk);
    addr = STAT;
    #1;
    n_cmp++; if (out_w !== HIZ) begin n_err++; $display("FAIL rd0_out_hiz: got %h want %h", out_w, HIZ); end
    addr = '0;
  endtask

  task automatic test_tx_stream;
    logic       vs [8];
    logic [7:0] cs [8];
    logic       ev [8];
    ev = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tx_ready = 1'b1;
    bus_write(BASE, 8'h48);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_latency_early: got %b want 0", tx_valid); end
    bus_write(BASE, 8'h69);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vs[i] = tx_valid;
      cs[i] = tx_char;
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (vs[i] !== ev[i]) begin n_err++; $display("FAIL tx_valid_seq[%0d]: got %b want %b", i, vs[i], ev[i]); end
    end
    n_cmp++; if (cs[0] !== 8'h48) begin n_err++; $display("FAIL tx_char_first: got %h want 48", cs[0]); end
    n_cmp++; if (cs[4] !== 8'h69) begin n_err++; $display("FAIL tx_char_second: got %h want 69", cs[4]); end
    repeat (6) @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow;
    logic [31:0] v;
    logic [7:0]  got [16];
    int          n;
    n = 0;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(BASE, 8'h10 + 8'(i));
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0000_0825) begin n_err++; $display("FAIL tx_ovf_status: got %h want %h", v, 32'h825); end
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0000_0805) begin n_err++; $display("FAIL tx_ovf_cleared: got %h want %h", v, 32'h805); end
    n_cmp++; if (tx_valid !== 1'b1 || tx_char !== 8'h10) begin n_err++; $display("FAIL tx_hold: got %b/%h want 1/10", tx_valid, tx_char); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (tx_valid && tx_ready && n < 16) begin
        got[n] = tx_char;
        n++;
      end
      @(negedge clk);
    end
    n_cmp++; if (n !== 8) begin n_err++; $display("FAIL tx_drain_count: got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (got[i] !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL tx_drain[%0d]: got %h want %h", i, got[i], 8'h10 + 8'(i)); end
    end
    tx_ready = 1'b0;
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0000_0006) begin n_err++; $display("FAIL tx_drained_status: got %h want %h", v, 32'h6); end
  endtask

  task automatic test_rx_read;
    logic [31:0] v;
    rx_pulse(8'h41);
    rx_pulse(8'h42);
    bus_read(BASE, v);
    n_cmp++; if (v !== 32'h41) begin n_err++; $display("FAIL rx_read1: got %h want %h", v, 32'h41); end
    bus_read(BASE, v);
    n_cmp++; if (v !== 32'h42) begin n_err++; $display("FAIL rx_read2: got %h want %h", v, 32'h42); end
    bus_read(BASE, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rx_read_empty: got %h want 0", v); end
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0000_0006) begin n_err++; $display("FAIL rx_empty_status: got %h want %h", v, 32'h6); end
  endtask

  task automatic test_rx_full_pop;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) rx_pulse(8'h50 + 8'(i));
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0008_000A) begin n_err++; $display("FAIL rx_full_status: got %h want %h", v, 32'h0008_000A); end
    @(negedge clk);
    addr = BASE;
    rd = 1'b1;
    rx_char = 8'h99;
    rx_valid = 1'b1;
    #1 v = out_w;
    @(posedge clk);
    #1 rd = 1'b0;
    rx_valid = 1'b0;
    addr = '0;
    n_cmp++; if (v !== 32'h50) begin n_err++; $display("FAIL rx_full_pop_data: got %h want %h", v, 32'h50); end
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0007_0012) begin n_err++; $display("FAIL rx_ovf_status: got %h want %h", v, 32'h0007_0012); end
    for (int i = 1; i < 8; i++) begin
      bus_read(BASE, v);
      n_cmp++; if (v !== 32'h50 + i) begin n_err++; $display("FAIL rx_drain[%0d]: got %h want %h", i, v, 32'h50 + i); end
    end
    bus_read(BASE, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rx_drop_absent: got %h want 0", v); end
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0000_0006) begin n_err++; $display("FAIL rx_ovf_cleared: got %h want %h", v, 32'h6); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    tx_ready = 1'b0;
    bus_write(BASE, 8'hAB);
    bus_write(BASE, 8'hCD);
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b1 || tx_char !== 8'hAB) begin n_err++; $display("FAIL pre_reset_tx: got %b/%h want 1/ab", tx_valid, tx_char); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_char !== 8'h00) begin n_err++; $display("FAIL async_reset_char: got %h want 00", tx_char); end
    @(negedge clk);
    rst = 1'b1;
    bus_read(STAT, v);
    n_cmp++; if (v !== 32'h0000_0006) begin n_err++; $display("FAIL post_reset_status: got %h want %h", v, 32'h6); end
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_tx_overflow();
    test_rx_read();
    test_rx_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_tty_fifo.md
MMIO_TTY_FIFO -- requirements
Module: mmio_tty_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h4000: address of the DATA register; the STATUS register is at BASE_ADDR+1.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: width of addr.
REQ-003 SHALL have parameter DEPTH, default 8: entries per FIFO; power of two, at least 2.
REQ-004 SHALL have parameter TX_GAP, default 2: idle cycles forced after each tx transfer; 0 allowed.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port addr, input, ADDR_WIDTH bits: bus address.
REQ-008 SHALL have port data, input, 32 bits: write data; only bits [7:0] are used for DATA.
REQ-009 SHALL have port out, output, 32 bits: read data; tri-state.
REQ-010 SHALL have ports rd and wr, inputs, 1 bit each: bus read and write strobes.
REQ-011 SHALL have ports tx_char (output, 8 bits), tx_valid (output, 1 bit) and tx_ready (input, 1 bit): terminal sink handshake.
REQ-012 SHALL have ports rx_char (input, 8 bits) and rx_valid (input, 1 bit): keyboard source; no backpressure.

Function
REQ-013 SHALL decode sel_data as addr==BASE_ADDR and sel_stat as addr==BASE_ADDR+1, exact compare, with X/Z bits never matching.
REQ-014 SHALL drive out only while rd is high and sel_data or sel_stat is true; out SHALL be high-Z otherwise, including during reset.
REQ-015 SHALL present read data combinationally in the same cycle as rd.
REQ-016 SHALL apply pops, pushes and clear-on-read at the rising edge that ends the access cycle.
REQ-017 SHALL, on wr with sel_data, push data[7:0] into the TX FIFO if it is not full at the start of the cycle.
REQ-018 SHALL, when that TX FIFO is full, drop the byte and set sticky tx_ovf; a same-cycle tx pop does not make room for it.
REQ-019 SHALL, on rd with sel_data, return {24'b0, RX head}, then pop the RX FIFO.
REQ-020 SHALL, on rd with sel_data and RX empty, return 32'h0 and not pop.
REQ-021 SHALL return STATUS on rd with sel_stat, laid out as:
- bit0 tx_full
- bit1 tx_empty
- bit2 rx_empty
- bit3 rx_full
- bit4 rx_ovf
- bit5 tx_ovf
- [15:8] tx_count
- [23:16] rx_count
- all other bits 0
REQ-022 SHALL clear rx_ovf and tx_ovf at the end of a STATUS read; an overflow in that same cycle wins and leaves the bit set.
REQ-023 SHALL ignore wr to STATUS.
REQ-024 SHALL push rx_char into the RX FIFO on each cycle rx_valid is high and RX is not full at the start of the cycle; a same-cycle pop does not make room.
REQ-025 SHALL, when RX is full, drop the rx_char and set sticky rx_ovf.
REQ-026 SHALL run the TX drain state machine as follows:
- IDLE: tx_valid=0; go to SEND when the TX FIFO is non-empty.
- SEND: tx_valid=1, tx_char=TX head; on tx_valid&&tx_ready, pop and go to GAP (TX_GAP>0) or IDLE (TX_GAP=0).
- GAP: tx_valid=0; count TX_GAP cycles, then go to IDLE.
REQ-027 SHALL give write-to-tx_valid latency of 2 cycles: a byte written into an empty TX FIFO in idle (push edge N) drives tx_valid high after edge N+1.
REQ-028 SHALL hold tx_char stable while tx_valid=1 and tx_ready=0.
REQ-029 SHALL make both FIFOs first-in first-out, with pointers wrapping modulo DEPTH and counts ranging 0..DEPTH.
REQ-030 SHALL saturate the 8-bit count fields at 255 when DEPTH exceeds 255.
REQ-031 SHALL allow a push and a pop on the same FIFO in one cycle when it is neither empty nor full, leaving the count unchanged.

Reset
REQ-032 SHALL, while rst=0, asynchronously force:
- both FIFOs empty
- pointers 0
- rx_ovf=0, tx_ovf=0
- FSM=IDLE, gap counter 0
- tx_valid=0, tx_char=8'h00
REQ-033 SHALL discard all FIFO contents when reset asserts mid-transfer, with no partial completion.
REQ-034 SHALL accept bus and rx activity from the first rising edge after rst deasserts.

Verification
REQ-035 Bench SHALL cover: reset, then STATUS read -> out=32'h0000_0006; out is high-Z when rd=0.
REQ-036 Bench SHALL cover: write 8'h48 then 8'h69, tx_ready=1, TX_GAP=2 -> tx_valid high 2 cycles after the first push, bytes 48 then 69, 3 low cycles between them.
REQ-037 Bench SHALL cover: tx_ready=0, write DEPTH+1 bytes -> STATUS shows tx_full=1, tx_ovf=1, tx_count=DEPTH; a second STATUS read shows tx_ovf=0; the dropped byte is never emitted.
REQ-038 Bench SHALL cover: rx_valid pulses 8'h41, 8'h42, then DATA reads -> 32'h41, 32'h42, then 32'h0 with rx_empty=1.
REQ-039 Bench SHALL cover: RX full while rx_valid and a DATA read occur in the same cycle -> the head is popped, the new byte is dropped, rx_ovf=1, rx_count=DEPTH-1.
REQ-040 Bench SHALL cover: rst pulsed low while tx_valid=1 -> tx_valid falls immediately (asynchronous), STATUS reads 32'h0000_0006.
